// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues one-outstanding reads to
// instruction memory, buffers returned words in a small FIFO and presents the
// FIFO head to decode. A taken branch redirects the PC, flushes the FIFO and
// discards any response still in flight.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemValid,
    input  logic [31:0]       IMemData,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              InstrValid,
    input  logic              InstrReady,
    input  logic              Branch,
    input  logic              ALUZero,
    input  logic [ADDR_W-1:0] BranchTarget
);

    localparam int unsigned      PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned      CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        HOLD,
        FETCH,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] target;
    logic              drop;
    logic              drop_next;
    logic              taken;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after_pop;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [31:0]       buf_word [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pcp4 [BUF_DEPTH];

    assign taken           = Branch & ALUZero;
    assign target          = BranchTarget & ~ADDR_W'(3);
    assign InstrValid      = (count != '0);
    assign pop             = InstrValid & InstrReady;
    assign count_after_pop = count - CNT_W'(pop);

    assign IMemReq     = (state == FETCH);
    assign IMemAddr    = (state == FETCH) ? pc : req_addr;
    assign Instruction = InstrValid ? buf_word[rd_ptr] : '0;
    assign PCPlus4     = InstrValid ? buf_pcp4[rd_ptr] : '0;

    // Next-state, PC update, drop tracking and push decision.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        push       = 1'b0;
        case (state)
            HOLD: begin
                if (taken || (count_after_pop < DEPTH_CNT)) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                pc_next    = pc + ADDR_W'(4);
                state_next = WAIT;
                if (taken) begin
                    drop_next = 1'b1;
                end
            end
            WAIT: begin
                if (IMemValid) begin
                    drop_next = 1'b0;
                    if (taken || drop) begin
                        state_next = FETCH;
                    end else begin
                        push       = 1'b1;
                        state_next = ((count_after_pop + CNT_W'(1)) < DEPTH_CNT) ? FETCH : HOLD;
                    end
                end else if (taken) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = HOLD;
        endcase
        if (taken) begin
            pc_next = target;
        end
    end

    // Control registers: FSM state, PC, outstanding address, drop flag, FIFO pointers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= HOLD;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
            if (state == FETCH) begin
                req_addr <= pc;
            end
            if (taken) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage: word plus the address of the following instruction.
    always_ff @(posedge Clk) begin
        if (push) begin
            buf_word[wr_ptr] <= IMemData;
            buf_pcp4[wr_ptr] <= req_addr + ADDR_W'(4);
        end
    end

endmodule
